// File: rtl/prf_multiport_if.sv
// Bus bundle for the physical register file: operand reads, CDB writeback,
// rename allocation and the registered busy count.
interface prf_multiport_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int WIDTH      = 32,
    parameter int NUM_RD     = 4,
    parameter int NUM_WR     = 2
) ();
    logic [NUM_RD-1:0]            r_en;
    logic [NUM_RD*ADDR_WIDTH-1:0] r_addr;
    logic [NUM_RD*WIDTH-1:0]      dout;
    logic [NUM_RD-1:0]            rdy;
    logic [NUM_WR-1:0]            w_en;
    logic [NUM_WR*ADDR_WIDTH-1:0] w_addr;
    logic [NUM_WR*WIDTH-1:0]      din;
    logic                         alloc_en;
    logic [ADDR_WIDTH-1:0]        alloc_addr;
    logic [ADDR_WIDTH:0]          busy_cnt;

    modport master (
        output r_en, r_addr, w_en, w_addr, din, alloc_en, alloc_addr,
        input  dout, rdy, busy_cnt
    );

    modport slave (
        input  r_en, r_addr, w_en, w_addr, din, alloc_en, alloc_addr,
        output dout, rdy, busy_cnt
    );
endinterface

// File: rtl/prf_multiport.sv
// Multi-ported physical register file with per-register ready scoreboard,
// same-cycle write-to-read forwarding and a registered busy-register count.
module prf_multiport #(
    parameter int DEPTH      = 48,
    parameter int ADDR_WIDTH = 6,
    parameter int WIDTH      = 32,
    parameter int NUM_RD     = 4,
    parameter int NUM_WR     = 2
) (
    input logic            clk,
    input logic            reset,
    prf_multiport_if.slave bus
);
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [WIDTH-1:0]    mem_d [DEPTH];
    logic [DEPTH-1:0]    ready_q, ready_d;
    logic [ADDR_WIDTH:0] busy_cnt_q, busy_cnt_d;
    logic [WIDTH-1:0]    rd_data [NUM_RD];
    logic [NUM_RD-1:0]   rd_rdy;
    logic                wr_conflict;

    // Register 0 and anything at or beyond DEPTH is never stored or tracked.
    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return (a != '0) && ({1'b0, a} < DEPTH_W);
    endfunction

    // NOTE: ports are scanned highest-first with blocking assignments, so the
    // lowest matching port is applied last and wins; alloc then overrides ready.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
        ready_d = ready_q;
        for (int j = NUM_WR-1; j >= 0; j--) begin
            if (bus.w_en[j] && in_range(bus.w_addr[j*ADDR_WIDTH +: ADDR_WIDTH])) begin
                mem_d[bus.w_addr[j*ADDR_WIDTH +: ADDR_WIDTH]]   = bus.din[j*WIDTH +: WIDTH];
                ready_d[bus.w_addr[j*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b1;
            end
        end
        if (bus.alloc_en && in_range(bus.alloc_addr)) ready_d[bus.alloc_addr] = 1'b0;
    end

    // Counting the whole scoreboard yields exactly the net of 1->0 and 0->1
    // transitions each cycle and cannot drift out of [0, DEPTH-1].
    always_comb begin
        busy_cnt_d = '0;
        for (int i = 1; i < DEPTH; i++) begin
            if (!ready_d[i]) busy_cnt_d = busy_cnt_d + (ADDR_WIDTH+1)'(1);
        end
    end

    // NOTE: the data array carries an async reset like ordinary flops because
    // reads after reset must return zero; it cannot map onto a RAM macro.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            ready_q    <= '1;
            busy_cnt_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
            ready_q    <= ready_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    always_comb begin
        logic [ADDR_WIDTH-1:0] ra;
        ra = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            rd_data[i] = '0;
            rd_rdy[i]  = 1'b1;
            ra         = bus.r_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            if (!reset && bus.r_en[i] && in_range(ra)) begin
                rd_data[i] = mem_q[ra];
                rd_rdy[i]  = ready_q[ra];
                for (int j = NUM_WR-1; j >= 0; j--) begin
                    if (bus.w_en[j] && bus.w_addr[j*ADDR_WIDTH +: ADDR_WIDTH] == ra) begin
                        rd_data[i] = bus.din[j*WIDTH +: WIDTH];
                        rd_rdy[i]  = 1'b1;
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_dout
        assign bus.dout[g*WIDTH +: WIDTH] = rd_data[g];
    end
    assign bus.rdy      = rd_rdy;
    assign bus.busy_cnt = busy_cnt_q;

    always_comb begin
        wr_conflict = 1'b0;
        for (int j = 0; j < NUM_WR; j++) begin
            for (int k = j + 1; k < NUM_WR; k++) begin
                if (bus.w_en[j] && bus.w_en[k] &&
                    bus.w_addr[j*ADDR_WIDTH +: ADDR_WIDTH] == bus.w_addr[k*ADDR_WIDTH +: ADDR_WIDTH] &&
                    in_range(bus.w_addr[j*ADDR_WIDTH +: ADDR_WIDTH]))
                    wr_conflict = 1'b1;
            end
        end
    end

    // Two CDB ports retiring into one register means rename issued a tag twice.
    a_wr_conflict: assert property (@(posedge clk) disable iff (reset) !wr_conflict)
        else $warning("prf_multiport: two write ports target the same register");
endmodule

// File: tb/tb_prf_multiport.sv
// Self-checking bench for prf_multiport: array model checked every cycle plus
// hand-computed directed expectations.
module tb_prf_multiport;
    localparam int DEPTH = 48;
    localparam int AW    = 6;
    localparam int W     = 32;
    localparam int NR    = 4;
    localparam int NW    = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    bit   run_cmp  = 1'b1;

    prf_multiport_if #(.ADDR_WIDTH(AW), .WIDTH(W), .NUM_RD(NR), .NUM_WR(NW)) bus ();

    prf_multiport #(
        .DEPTH(DEPTH), .ADDR_WIDTH(AW), .WIDTH(W), .NUM_RD(NR), .NUM_WR(NW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: register contents and ready flags as plain arrays.
    logic [W-1:0] m_mem [DEPTH];
    bit           m_rdy [DEPTH];
    int           wa;
    bit           shadowed;

    function automatic bit addr_ok(input int a);
        return a != 0 && a < DEPTH;
    endfunction

    function automatic int model_busy();
        int n = 0;
        for (int i = 1; i < DEPTH; i++) if (!m_rdy[i]) n++;
        return n;
    endfunction

    function automatic void exp_read(input int i, output logic [W-1:0] d, output logic r);
        int a;
        d = '0;
        r = 1'b1;
        a = int'(bus.r_addr[i*AW +: AW]);
        if (reset || !bus.r_en[i] || !addr_ok(a)) return;
        for (int j = 0; j < NW; j++) begin
            if (bus.w_en[j] && int'(bus.w_addr[j*AW +: AW]) == a) begin
                d = bus.din[j*W +: W];
                return;
            end
        end
        d = m_mem[a];
        r = m_rdy[a];
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_mem[i] = '0;
                m_rdy[i] = 1'b1;
            end
        end else begin
            for (int j = 0; j < NW; j++) begin
                wa = int'(bus.w_addr[j*AW +: AW]);
                shadowed = 1'b0;
                for (int k = 0; k < j; k++)
                    if (bus.w_en[k] && int'(bus.w_addr[k*AW +: AW]) == wa) shadowed = 1'b1;
                if (bus.w_en[j] && addr_ok(wa) && !shadowed) begin
                    m_mem[wa] = bus.din[j*W +: W];
                    m_rdy[wa] = 1'b1;
                end
            end
            if (bus.alloc_en && addr_ok(int'(bus.alloc_addr))) m_rdy[bus.alloc_addr] = 1'b0;
        end
    end

    // Compare process: every read port and the busy count, each falling edge.
    always @(negedge clk) begin
        logic [W-1:0] ed;
        logic         er;
        if (run_cmp) begin
            for (int i = 0; i < NR; i++) begin
                exp_read(i, ed, er);
                check($sformatf("model_dout%0d", i), bus.dout[i*W +: W], ed);
                check($sformatf("model_rdy%0d", i), bus.rdy[i], er);
            end
            check("model_busy_cnt", bus.busy_cnt, model_busy());
        end
    end

    task automatic idle();
        bus.r_en       = '0;
        bus.r_addr     = '0;
        bus.w_en       = '0;
        bus.w_addr     = '0;
        bus.din        = '0;
        bus.alloc_en   = 1'b0;
        bus.alloc_addr = '0;
    endtask

    task automatic rd(input int i, input int a);
        bus.r_en[i]            = 1'b1;
        bus.r_addr[i*AW +: AW] = AW'(a);
    endtask

    task automatic wr(input int j, input int a, input logic [W-1:0] d);
        bus.w_en[j]            = 1'b1;
        bus.w_addr[j*AW +: AW] = AW'(a);
        bus.din[j*W +: W]      = d;
    endtask

    task automatic alloc(input int a);
        bus.alloc_en   = 1'b1;
        bus.alloc_addr = AW'(a);
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Empty file: every register reads zero and ready.
        for (int a = 0; a < DEPTH; a += NR) begin
            idle();
            for (int i = 0; i < NR; i++) rd(i, a + i);
            mid();
            check("t1_dout_zero", bus.dout, '0);
            check("t1_rdy_all", bus.rdy, 4'hF);
            check("t1_busy_zero", bus.busy_cnt, 0);
            cyc();
        end
        idle();
        rd(0, 50); rd(1, 55); rd(2, 60); rd(3, 63);
        mid();
        check("t1_oor_dout", bus.dout, '0);
        check("t1_oor_rdy", bus.rdy, 4'hF);
        cyc();

        // Alloc, then CDB writeback with same-cycle forwarding.
        idle(); alloc(5); mid(); cyc();
        idle(); rd(0, 5); mid();
        check("t2_rdy_after_alloc", bus.rdy[0], 1'b0);
        check("t2_busy_one", bus.busy_cnt, 1);
        cyc();
        idle(); rd(0, 5); wr(1, 5, 32'hDEADBEEF); mid();
        check("t2_fwd_dout", bus.dout[0 +: W], 32'hDEADBEEF);
        check("t2_fwd_rdy", bus.rdy[0], 1'b1);
        cyc();
        idle(); rd(0, 5); mid();
        check("t2_stored_dout", bus.dout[0 +: W], 32'hDEADBEEF);
        check("t2_stored_rdy", bus.rdy[0], 1'b1);
        check("t2_busy_zero", bus.busy_cnt, 0);
        cyc();

        // Both write ports on one register: port 0 wins.
        idle(); wr(0, 9, 32'h11); wr(1, 9, 32'h22);
        for (int i = 0; i < NR; i++) rd(i, 9);
        mid();
        check("t3_fwd_low_port", bus.dout, {4{32'h0000_0011}});
        cyc();
        idle(); rd(0, 9); mid();
        check("t3_stored_low_port", bus.dout[0 +: W], 32'h11);
        cyc();

        // Register 0 ignores writes and allocs.
        idle(); wr(0, 0, 32'hFFFFFFFF); alloc(0);
        for (int i = 0; i < NR; i++) rd(i, 0);
        mid();
        check("t4_zero_dout", bus.dout, '0);
        check("t4_zero_rdy", bus.rdy, 4'hF);
        cyc();
        idle(); rd(0, 0); mid();
        check("t4_zero_after", bus.dout[0 +: W], 32'h0);
        check("t4_busy_same", bus.busy_cnt, 0);
        cyc();

        // Alloc and write on the same register: data lands, alloc wins ready.
        idle(); alloc(12); wr(0, 12, 32'h1234); rd(0, 12); mid();
        check("t5_fwd_dout", bus.dout[0 +: W], 32'h1234);
        check("t5_fwd_rdy", bus.rdy[0], 1'b1);
        cyc();
        idle(); rd(0, 12); mid();
        check("t5_dout", bus.dout[0 +: W], 32'h1234);
        check("t5_rdy_cleared", bus.rdy[0], 1'b0);
        check("t5_busy_one", bus.busy_cnt, 1);
        cyc();

        // Fill the scoreboard, then boundary behaviour of busy_cnt.
        for (int a = 1; a < DEPTH; a++) begin
            idle(); alloc(a); cyc();
        end
        idle(); mid();
        check("t6_busy_full", bus.busy_cnt, 47);
        cyc();
        idle(); alloc(3); mid(); cyc();
        idle(); wr(0, 3, 32'hAAAA); mid();
        check("t6_realloc_same", bus.busy_cnt, 47);
        cyc();
        idle(); wr(1, 3, 32'hBBBB); mid();
        check("t6_first_write", bus.busy_cnt, 46);
        cyc();
        idle(); rd(0, 3); mid();
        check("t6_second_write", bus.busy_cnt, 46);
        check("t6_dout3", bus.dout[0 +: W], 32'hBBBB);
        cyc();

        // Out-of-range write and alloc are dropped.
        idle(); wr(0, 50, 32'h7777); alloc(60); rd(1, 50); mid();
        check("t7_oor_fwd_dout", bus.dout[W +: W], 32'h0);
        check("t7_oor_fwd_rdy", bus.rdy[1], 1'b1);
        cyc();
        idle(); mid();
        check("t7_oor_busy", bus.busy_cnt, 46);
        cyc();

        // Asynchronous reset between edges clears outputs immediately.
        idle(); rd(0, 12); wr(1, 20, 32'h5555); mid();
        check("t8_pre_reset", bus.dout[0 +: W], 32'h1234);
        #2 reset = 1'b1;
        #1;
        check("t8_async_dout", bus.dout, '0);
        check("t8_async_rdy", bus.rdy, 4'hF);
        check("t8_async_busy", bus.busy_cnt, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        idle(); rd(0, 12); rd(1, 20); mid();
        check("t8_post_dout", bus.dout, '0);
        check("t8_post_rdy", bus.rdy, 4'hF);
        check("t8_post_busy", bus.busy_cnt, 0);
        cyc();

        run_cmp = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/prf_multiport.md
Name: prf_multiport

Overview:
Parametrised physical register file for the Tomasulo core, successor to the fixed 48x32 4R/1W PRF. It provides NUM_RD read ports, NUM_WR write ports and a per-register ready (valid) scoreboard bit. The ready bit is cleared when rename allocates a destination register and set when the CDB writes it back. It sits between rename/dispatch (alloc, operand read) and the CDB (writeback).

Parameters:
DEPTH, 48, number of physical registers; register 0 hardwired to zero.
ADDR_WIDTH, 6, address width; must satisfy 2^ADDR_WIDTH >= DEPTH.
WIDTH, 32, data width.
NUM_RD, 4, number of read ports.
NUM_WR, 2, number of write ports.

Ports:
clk  input  1  clock, posedge.
reset  input  1  asynchronous, active-high reset.
r_en  input  NUM_RD  per-port read enable.
r_addr  input  NUM_RD*ADDR_WIDTH  read addresses; port i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
dout  output  NUM_RD*WIDTH  read data, same slicing.
rdy  output  NUM_RD  ready bit of the addressed register.
w_en  input  NUM_WR  per-port write enable.
w_addr  input  NUM_WR*ADDR_WIDTH  write addresses.
din  input  NUM_WR*WIDTH  write data.
alloc_en  input  1  clear the ready bit of alloc_addr.
alloc_addr  input  ADDR_WIDTH  register being allocated at rename.
busy_cnt  output  ADDR_WIDTH+1  registered count of registers with ready=0.

Behaviour:
- Reset (async, active-high): all data entries go to 0, all ready bits go to 1, busy_cnt goes to 0. While reset is asserted, reads return dout=0 and rdy=1.
- Reads are combinational (0-cycle). If r_en[i]=0 or r_addr=0, then dout=0 and rdy=1.
- Write-to-read forwarding:
  - If any w_en[j] is set with w_addr[j]==r_addr[i]!=0, dout=din[j] and rdy=1 in the same cycle.
  - If several write ports match, the lowest j wins.
  - Otherwise dout=mem[r_addr] and rdy=ready[r_addr].
- Writes update on posedge. Each w_en[j] with w_addr!=0 writes din[j] and sets ready. Writes to address 0 are ignored.
- Two write ports to the same address in one cycle: the lowest-index port's data is stored. This is a protocol error and the assertion flags it.
- Alloc: on posedge with alloc_en=1 and alloc_addr!=0, ready[alloc_addr] is cleared. alloc_addr=0 is ignored.
- Alloc and write to the same address in the same cycle: data is written and alloc wins, so ready ends at 0. Same-cycle forwarding still gives rdy=1 and dout=din for that cycle.
- Out-of-range addresses (>= DEPTH): reads return 0 with rdy=1; writes and allocs are ignored.
- busy_cnt tracks the number of entries 1..DEPTH-1 with ready=0. Per cycle it changes by +1 for an effective 1->0 transition and -1 for each effective 0->1 transition.
  - Writes to an already-ready register do not change busy_cnt.
  - Alloc of an already-busy register does not change busy_cnt.
  - busy_cnt never exceeds DEPTH-1 and never underflows.
- No internal stalls; all ports are usable every cycle.
- Reset asserted mid-operation overrides any pending write or alloc in that cycle.

Test Plan:
1. Reset then read all ports at addresses 0..47 -> dout=0, rdy=1, busy_cnt=0. Assert reset asynchronously between edges -> outputs clear immediately.
2. alloc 5 at cycle 0; read r_addr=5 at cycle 1 -> rdy=0, busy_cnt=1. At cycle 2 set w_en[1]=1, w_addr=5, din=0xDEADBEEF; the read in the same cycle -> dout=0xDEADBEEF, rdy=1. At cycle 3 -> rdy=1, busy_cnt=0.
3. Both write ports target addr 9 with din 0x11 (port 0) and 0x22 (port 1); all four reads at 9 -> every dout=0x11. Next cycle mem[9]=0x11.
4. Write addr 0 with 0xFFFFFFFF plus alloc 0 -> reads of 0 stay 0 with rdy=1; busy_cnt unchanged.
5. Same cycle: alloc 12 and write 12 with 0x1234 -> read that cycle gives 0x1234 with rdy=1. Next cycle: dout=0x1234, rdy=0, busy_cnt +1.
6. Allocate 1..47 back-to-back -> busy_cnt reaches 47. Re-alloc 3 -> stays 47. Write 3 twice -> 46 after the first write, unchanged after the second.
